// File: rtl/wr_ddr_burst_ctrl_if.sv
// Write-side DDR bus bundle for wr_ddr_burst_ctrl.
// Carries the address, write-data and write-response channels.
// The controller uses the master modport and the memory side uses the slave modport.
interface wr_ddr_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 28
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  logic [255:0]          wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/wr_ddr_burst_ctrl.sv
// wr_ddr_burst_ctrl: moves fixed-length bursts from a write FIFO to a DDR write port.
// Each burst goes through the states IDLE, ADDR, DATA and RESP.
// The burst address walks base_addr + offset*BURST_LEN*32 and wraps after FRAME_BURSTS bursts.
// A 2-entry skid buffer decouples the FIFO read latency from W-channel backpressure.
// Optional feature: define WR_DDR_BURST_CTRL_UNDERFLOW_CHK_EN to enable the sticky
// err_underflow flag. It flags a FIFO read issued while the FIFO is empty.
module wr_ddr_burst_ctrl #(
  parameter int BURST_LEN    = 16,
  parameter int FRAME_BURSTS = 3600,
  parameter int ADDR_WIDTH   = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [9:0]            fifo_rd_water_level,
  input  logic                  fifo_rd_empty,
  output logic                  fifo_rd_en,
  input  logic [255:0]          fifo_rd_data,
  wr_ddr_burst_ctrl_if.master   axi,
  output logic                  busy,
  output logic                  err_underflow
);

  localparam int OFF_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int CNT_W = 9;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 32);
  localparam logic [CNT_W-1:0]      BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BURST_LEN - 1);
  localparam logic [OFF_W-1:0]      LAST_OFFSET = OFF_W'(FRAME_BURSTS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t           state;
  state_t           next_state;
  logic [OFF_W-1:0] offset;
  logic             pending;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [1:0]       buf_cnt;
  logic             rd_inflight;
  logic [255:0]     buf0;
  logic [255:0]     buf1;
  logic             beat;
  logic             push;
  logic             resp_exit;

  assign beat      = axi.wvalid & axi.wready;
  assign push      = rd_inflight;
  assign resp_exit = (state == RESP) && axi.bvalid;

  assign busy       = (state != IDLE);
  assign axi.awlen  = 8'(BURST_LEN - 1);
  assign axi.awaddr = base_addr + ADDR_WIDTH'(offset) * BURST_BYTES;
  assign axi.wvalid = (state == DATA) && (buf_cnt != 2'd0);
  assign axi.wlast  = axi.wvalid && (beat_cnt == LAST_BEAT);
  assign axi.wdata  = buf0;

  // State register; reset drops any burst in progress back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake outputs; FIFO reads stop once two words are buffered or on their way.
  always_comb begin
    next_state = state;
    axi.awvalid = 1'b0;
    axi.bready = 1'b0;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (fifo_rd_water_level >= 10'(BURST_LEN))) next_state = ADDR;
      end
      ADDR: begin
        axi.awvalid = 1'b1;
        if (axi.awready) next_state = DATA;
      end
      DATA: begin
        fifo_rd_en = (rd_cnt < BURST_CNT) &&
                     (({1'b0, buf_cnt} + {2'b00, rd_inflight}) < 3'd2);
        if (beat && axi.wlast) next_state = RESP;
      end
      RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Per-burst beat and read counters; they restart whenever the FSM is outside DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      rd_cnt      <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= fifo_rd_en;
      if (state != DATA) begin
        beat_cnt <= '0;
        rd_cnt   <= '0;
      end else begin
        if (beat)       beat_cnt <= beat_cnt + 1'b1;
        if (fifo_rd_en) rd_cnt   <= rd_cnt + 1'b1;
      end
    end
  end

  // Two-entry skid buffer; buf0 is the head and drives wdata directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      case ({push, beat})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= fifo_rd_data;
          else                 buf1 <= fifo_rd_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= fifo_rd_data;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Burst offset: a frame_start seen mid-burst is remembered and takes priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset  <= '0;
      pending <= 1'b0;
    end else if ((state == IDLE) && frame_start) begin
      offset <= '0;
    end else if (resp_exit) begin
      pending <= 1'b0;
      if (pending || frame_start)   offset <= '0;
      else if (offset == LAST_OFFSET) offset <= '0;
      else                          offset <= offset + 1'b1;
    end else if (frame_start && (state != IDLE)) begin
      pending <= 1'b1;
    end
  end

`ifdef WR_DDR_BURST_CTRL_UNDERFLOW_CHK_EN
  // Sticky flag for a FIFO read issued while the FIFO reports empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_underflow <= 1'b0;
    else if (fifo_rd_en && fifo_rd_empty) err_underflow <= 1'b1;
  end
`else
  // Without the check the empty flag has no consumer.
  logic unused_empty;
  assign unused_empty  = fifo_rd_empty;
  assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ddr_burst_ctrl.sv
// Directed testbench for wr_ddr_burst_ctrl (BURST_LEN=16, FRAME_BURSTS=4).
// A FIFO model supplies {8{word}} with word incrementing on each read.
// The memory side accepts addresses at once and answers bready with bvalid on the next edge.
module tb_wr_ddr_burst_ctrl;
  localparam int BURST_LEN    = 16;
  localparam int FRAME_BURSTS = 4;
  localparam int ADDR_WIDTH   = 28;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  enable;
  logic                  frame_start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [9:0]            water;
  logic                  fifo_rd_empty;
  logic                  fifo_rd_en;
  logic [255:0]          fifo_rd_data = '0;
  logic                  busy;
  logic                  err_underflow;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]           fifo_word = 32'd0;
  logic [31:0]           exp_word;
  int                    beats_seen;
  int                    reads_seen;
  int                    aw_seen_cnt;
  logic [ADDR_WIDTH-1:0] aw_seen;
  logic                  toggle_w;
  logic                  stall_prev;
  logic [255:0]          stall_data;
  logic                  lat_armed;
  int                    lat_cnt;
  logic                  exp_err;

  wr_ddr_burst_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) axi ();

  wr_ddr_burst_ctrl #(
    .BURST_LEN   (BURST_LEN),
    .FRAME_BURSTS(FRAME_BURSTS),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .frame_start        (frame_start),
    .base_addr          (base_addr),
    .fifo_rd_water_level(water),
    .fifo_rd_empty      (fifo_rd_empty),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_rd_data       (fifo_rd_data),
    .axi                (axi),
    .busy               (busy),
    .err_underflow      (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // FIFO model: one-cycle read latency, sequential words.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= {8{fifo_word}};
      fifo_word    <= fifo_word + 32'd1;
    end
  end

  // Bus responder and monitor; decisions made here apply at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      lat_armed  = 1'b0;
    end else begin
      if (toggle_w) axi.wready = ~axi.wready;
      else          axi.wready = 1'b1;
      axi.bvalid = axi.bready;
      if (stall_prev) begin
        checkOutput("w_hold_valid", axi.wvalid, 1'b1);
        checkOutput("w_hold_data", axi.wdata, stall_data);
      end
      if (axi.awvalid && axi.awready) begin
        aw_seen_cnt++;
        aw_seen = axi.awaddr;
        checkOutput("awlen", axi.awlen, 8'd15);
        lat_cnt   = 0;
        lat_armed = 1'b1;
      end else if (lat_armed) begin
        lat_cnt++;
        if (axi.wvalid) begin
          checkOutput("wvalid_latency_ok", lat_cnt <= 3, 1'b1);
          lat_armed = 1'b0;
        end
      end
      if (fifo_rd_en) reads_seen++;
      if (axi.wvalid && axi.wready) begin
        checkOutput("beat_data", axi.wdata, {8{exp_word}});
        checkOutput("wlast", axi.wlast, beats_seen == BURST_LEN - 1);
        exp_word = exp_word + 32'd1;
        beats_seen++;
      end
      stall_prev = axi.wvalid && !axi.wready;
      stall_data = axi.wdata;
    end
  end

  task automatic waitBusy(input logic level, input string tag);
    int n = 0;
    while (busy !== level && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, busy, level);
  endtask

  // Runs one burst. mode 1 pulses frame_start in DATA, mode 2 pulses it on RESP exit,
  // and mode 3 forces the FIFO empty flag during DATA.
  task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] exp_addr, input bit drop_early, input int mode, input string name);
    int n;
    beats_seen  = 0;
    reads_seen  = 0;
    aw_seen_cnt = 0;
    enable = 1'b1;
    waitBusy(1'b1, {name, "_busy_rise"});
    if (drop_early) enable = 1'b0;
    if (mode == 1 || mode == 3) begin
      n = 0;
      while (!axi.wvalid && n < 100) begin @(negedge clk); n++; end
      checkOutput({name, "_reach_data"}, axi.wvalid, 1'b1);
      if (mode == 1) begin
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
      end else begin
        fifo_rd_empty = 1'b1;
      end
    end else if (mode == 2) begin
      n = 0;
      while (!axi.bready && n < 200) begin @(negedge clk); n++; end
      checkOutput({name, "_reach_resp"}, axi.bready, 1'b1);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
    waitBusy(1'b0, {name, "_busy_fall"});
    enable = 1'b0;
    fifo_rd_empty = 1'b0;
    @(negedge clk);
    checkOutput({name, "_awaddr"}, aw_seen, exp_addr);
    checkOutput({name, "_aw_count"}, aw_seen_cnt, 1);
    checkOutput({name, "_beats"}, beats_seen, BURST_LEN);
    checkOutput({name, "_reads"}, reads_seen, BURST_LEN);
    checkOutput({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
`ifdef WR_DDR_BURST_CTRL_UNDERFLOW_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0;
    base_addr = 28'h0100000; water = 10'd16; fifo_rd_empty = 1'b0;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
    toggle_w = 1'b0; exp_word = 32'd0;
    beats_seen = 0; reads_seen = 0; aw_seen_cnt = 0; aw_seen = '0;
    stall_prev = 1'b0; stall_data = '0; lat_armed = 1'b0; lat_cnt = 0;
    repeat (3) @(negedge clk);

    checkOutput("rst_awvalid", axi.awvalid, 1'b0);
    checkOutput("rst_wvalid", axi.wvalid, 1'b0);
    checkOutput("rst_wlast", axi.wlast, 1'b0);
    checkOutput("rst_bready", axi.bready, 1'b0);
    checkOutput("rst_rd_en", fifo_rd_en, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_wdata", axi.wdata, 256'd0);
    checkOutput("rst_awlen", axi.awlen, 8'd15);
    checkOutput("rst_awaddr", axi.awaddr, 28'h0100000);
    checkOutput("rst_err", err_underflow, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic burst at offset 0; enable drops as soon as the burst starts.
    applyStimulus(28'h0100000, 1'b1, 0, "basic");

    // wready toggling every cycle.
    toggle_w = 1'b1;
    applyStimulus(28'h0100200, 1'b0, 0, "toggle");
    toggle_w = 1'b0;
    @(negedge clk);

    // Frame wrap: frame_start in IDLE clears the offset, then four bursts and a wrap.
    water = 10'd64;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    applyStimulus(28'h0100000, 1'b0, 0, "wrap0");
    applyStimulus(28'h0100200, 1'b0, 0, "wrap1");
    applyStimulus(28'h0100400, 1'b0, 0, "wrap2");
    applyStimulus(28'h0100600, 1'b0, 0, "wrap3");
    applyStimulus(28'h0100000, 1'b0, 0, "wrap4");

    // frame_start mid-burst, then frame_start coinciding with RESP exit.
    applyStimulus(28'h0100200, 1'b0, 0, "pre_fs");
    applyStimulus(28'h0100400, 1'b0, 1, "fs_data");
    applyStimulus(28'h0100000, 1'b0, 2, "after_fs");
    applyStimulus(28'h0100000, 1'b0, 0, "after_fs_resp");

    // Reset after beat 5 of a burst at offset 1.
    beats_seen = 0;
    enable = 1'b1;
    n = 0;
    while (beats_seen < 5 && n < 200) begin @(negedge clk); n++; end
    checkOutput("rst_mid_reach_beat5", beats_seen, 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("mid_rst_awvalid", axi.awvalid, 1'b0);
    checkOutput("mid_rst_wvalid", axi.wvalid, 1'b0);
    checkOutput("mid_rst_wlast", axi.wlast, 1'b0);
    checkOutput("mid_rst_bready", axi.bready, 1'b0);
    checkOutput("mid_rst_rd_en", fifo_rd_en, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_wdata", axi.wdata, 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_word = fifo_word;
    repeat (2) @(negedge clk);
    applyStimulus(28'h0100000, 1'b0, 0, "after_rst");
    checkOutput("err_before_empty", err_underflow, 1'b0);

    // FIFO empty forced during DATA.
    applyStimulus(28'h0100200, 1'b0, 3, "empty");
    checkOutput("err_underflow_set", err_underflow, exp_err);
    applyStimulus(28'h0100400, 1'b0, 0, "post_empty");
    checkOutput("err_underflow_held", err_underflow, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
